bist_lfsr_misr_ctrl: RTL and testbench

- Self-test wrapper stage for the combinational benchmark netlists, e.g. the 36-input/7-output interrupt-controller circuit.
- Upstream half: a Galois LFSR drives pseudo-random patterns onto the circuit-under-test (CUT) primary inputs.
- Downstream half: a MISR compacts the CUT primary outputs into a signature, which is compared against a golden value.
- A small FSM sequences a fixed-length run and reports done/pass.

---
 rtl/bist_lfsr_misr_ctrl_pkg.sv | 34 +++
 rtl/bist_lfsr_misr_ctrl_misr.sv | 58 +++++
 rtl/bist_lfsr_misr_ctrl.sv | 128 ++++++++++++
 tb/tb_bist_lfsr_misr_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bist_lfsr_misr_ctrl_pkg.sv
// Shared state encoding, default polynomials/seeds and the Galois shift helper
// used by both the pattern generator and the signature register.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bist_state_e;

  // Widest register the step helper can serve; callers cast the result back down.
  localparam int STEP_W = 64;

  localparam logic [35:0] DEF_LFSR_POLY = 36'h0_0200_0001;
  localparam logic [35:0] DEF_LFSR_SEED = 36'h0_0000_0001;
  localparam logic [15:0] DEF_MISR_POLY = 16'h1021;
  localparam logic [15:0] DEF_MISR_SEED = 16'h0000;

  function automatic logic [STEP_W-1:0] galois_step(
    input logic [STEP_W-1:0] value,
    input logic [STEP_W-1:0] mask,
    input int                width
  );
    logic [STEP_W-1:0] shifted;
    shifted = value << 1;
    if (value[width-1]) begin
      shifted = shifted ^ mask;
    end else begin
      shifted = shifted;
    end
    return shifted;
  endfunction

endpackage

// File: rtl/bist_lfsr_misr_ctrl_misr.sv
// Multiple-input signature register absorbing the CUT primary outputs.
// With BIST_RESP_REG_EN the response passes through one pipeline register first.
module bist_misr
  import bist_pkg::*;
#(
  parameter int                PO_W      = 7,
  parameter int                MISR_W    = 16,
  parameter logic [MISR_W-1:0] MISR_POLY = DEF_MISR_POLY,
  parameter logic [MISR_W-1:0] MISR_SEED = DEF_MISR_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              enable,
  input  logic [PO_W-1:0]   resp,
  output logic [MISR_W-1:0] signature
);

  logic [PO_W-1:0]   resp_in;
  logic [MISR_W-1:0] misr_next;

`ifdef BIST_RESP_REG_EN
  logic [PO_W-1:0] resp_q;

  // Response pipeline stage; always tracks the CUT so the drain cycle sees the last pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q <= '0;
    end else begin
      resp_q <= resp;
    end
  end

  assign resp_in = resp_q;
`else
  assign resp_in = resp;
`endif

  // Next signature: Galois shift of the register with the response folded in.
  always_comb begin
    misr_next = MISR_W'(galois_step(STEP_W'(signature), STEP_W'(MISR_POLY), MISR_W))
              ^ MISR_W'(resp_in);
  end

  // Signature register: reload on a new run, compact while enabled, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      signature <= MISR_SEED;
    end else if (load) begin
      signature <= MISR_SEED;
    end else if (enable) begin
      signature <= misr_next;
    end else begin
      signature <= signature;
    end
  end

endmodule

// File: rtl/bist_lfsr_misr_ctrl.sv
// LFSR/MISR self-test sequencer for a combinational CUT: drives patterns, compacts
// responses, reports done/pass. Optional macro BIST_RESP_REG_EN registers the response.
module bist_lfsr_misr_ctrl
  import bist_pkg::*;
#(
  parameter int                PI_W       = 36,
  parameter int                PO_W       = 7,
  parameter int                MISR_W     = 16,
  parameter logic [PI_W-1:0]   LFSR_POLY  = DEF_LFSR_POLY,
  parameter logic [PI_W-1:0]   LFSR_SEED  = DEF_LFSR_SEED,
  parameter logic [MISR_W-1:0] MISR_POLY  = DEF_MISR_POLY,
  parameter logic [MISR_W-1:0] MISR_SEED  = DEF_MISR_SEED,
  parameter int                N_PATTERNS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MISR_W-1:0] golden_sig,
  input  logic [PO_W-1:0]   cut_resp,
  output logic [PI_W-1:0]   cut_pat,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature
);

  localparam int CNT_W = $clog2(N_PATTERNS + 1);
`ifdef BIST_RESP_REG_EN
  // One extra drain cycle lets the registered response of the final pattern land.
  localparam int LAST_CNT = N_PATTERNS;
`else
  localparam int LAST_CNT = N_PATTERNS - 1;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_CNT);

  bist_state_e      state;
  logic [PI_W-1:0]  lfsr;
  logic [PI_W-1:0]  lfsr_next;
  logic [CNT_W-1:0] count;
  logic             misr_load;
  logic             misr_en;
  logic             lfsr_en;

  // Datapath enables derived from the registered FSM state.
  always_comb begin
    lfsr_next = PI_W'(galois_step(STEP_W'(lfsr), STEP_W'(LFSR_POLY), PI_W));
    misr_load = start && (state != RUN);
`ifdef BIST_RESP_REG_EN
    misr_en   = (state == RUN) && (count != '0);
    lfsr_en   = (state == RUN) && (count != LAST);
`else
    misr_en   = (state == RUN);
    lfsr_en   = (state == RUN);
`endif
  end

  // Sequencer: run-length counter, pattern LFSR and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lfsr  <= LFSR_SEED;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            lfsr  <= LFSR_SEED;
            count <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        RUN: begin
          if (lfsr_en) begin
            lfsr <= lfsr_next;
          end
          if (count == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            count <= count + CNT_W'(1'b1);
          end
        end
        DONE: begin
          if (start) begin
            state <= RUN;
            lfsr  <= LFSR_SEED;
            count <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          lfsr  <= LFSR_SEED;
          count <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // pass follows golden_sig live while the result is presented.
  always_comb begin
    cut_pat = lfsr;
    pass    = done && (signature == golden_sig);
  end

  bist_misr #(
    .PO_W      (PO_W),
    .MISR_W    (MISR_W),
    .MISR_POLY (MISR_POLY),
    .MISR_SEED (MISR_SEED)
  ) u_misr (
    .clk       (clk),
    .rst       (rst),
    .load      (misr_load),
    .enable    (misr_en),
    .resp      (cut_resp),
    .signature (signature)
  );

endmodule

// File: tb/tb_bist_lfsr_misr_ctrl.sv
// Randomized self-checking bench: three controllers (1, 2 and 24 patterns) against a
// sequence-level model of pattern generation and signature compaction.
`timescale 1ns/1ps
module tb_bist_lfsr_misr_ctrl;

  localparam int NI = 3;
  localparam int NP [NI] = '{1, 2, 24};
`ifdef BIST_RESP_REG_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start      [NI];
  logic [15:0] golden     [NI];
  logic [6:0]  resp       [NI];
  logic [35:0] pat        [NI];
  logic        busy       [NI];
  logic        done       [NI];
  logic        pass       [NI];
  logic [15:0] sig        [NI];
  int unsigned mode       [NI];
  logic [35:0] key        [NI];
  logic [35:0] fault_pat  [NI];
  logic [6:0]  fault_mask [NI];

  logic [35:0] mpat [0:64];
  logic [15:0] msig [0:64];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  // Stand-in CUT: zero, constant one, or a keyed hash of the pattern, with an optional fault.
  function automatic logic [6:0] cut_fn(logic [35:0] p, int unsigned m, logic [35:0] k,
                                        logic [35:0] fp, logic [6:0] fm);
    logic [63:0] h;
    logic [6:0]  r;
    h = 64'(p ^ k) * 64'h9E37_79B9_7F4A_7C15;
    case (m)
      0:       r = 7'h00;
      1:       r = 7'h01;
      default: r = h[63:57];
    endcase
    if (p == fp) r = r ^ fm;
    return r;
  endfunction

  function automatic logic [63:0] gstep(logic [63:0] v, logic [63:0] poly, int w);
    logic [63:0] lim;
    logic [63:0] r;
    lim = 64'd1 << w;
    r = (v * 64'd2) % lim;
    if (v >= (lim >> 1)) r = r ^ poly;
    return r;
  endfunction

  task automatic check_value(string tag, logic [63:0] observed, logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("FAIL %s: observed %0h required %0h", tag, observed, expected);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign resp[g] = cut_fn(pat[g], mode[g], key[g], fault_pat[g], fault_mask[g]);

    bist_lfsr_misr_ctrl #(.N_PATTERNS(NP[g])) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start[g]),
      .golden_sig (golden[g]),
      .cut_resp   (resp[g]),
      .cut_pat    (pat[g]),
      .busy       (busy[g]),
      .done       (done[g]),
      .pass       (pass[g]),
      .signature  (sig[g])
    );

    always @(negedge clk) check_value("lfsr_nonzero", 64'(pat[g] != 36'h0), 64'd1);
  end

  // Expected pattern i and signature after i absorbed responses.
  task automatic build_model(int g);
    logic [63:0] p;
    logic [63:0] s;
    p = 64'h1;
    s = 64'h0;
    for (int i = 0; i <= NP[g]; i++) begin
      mpat[i] = 36'(p);
      msig[i] = 16'(s);
      s = gstep(s, 64'h1021, 16) ^ 64'(cut_fn(36'(p), mode[g], key[g], fault_pat[g], fault_mask[g]));
      p = gstep(p, 64'h0_0200_0001, 36);
    end
  endtask

  task automatic run(int g, int inject_at, int rst_at, bit fault);
    int          n;
    int          lat;
    int          cyc;
    int          ab;
    logic [15:0] clean;
    n = NP[g];
    lat = n + EXTRA;
    fault_mask[g] = 7'h00;
    build_model(g);
    clean = msig[n];
    if (fault) begin
      fault_pat[g]  = mpat[10];
      fault_mask[g] = 7'(1 << $urandom_range(6, 0));
      build_model(g);
    end
    golden[g] = clean;
    @(negedge clk);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    cyc = 0;
    while (!done[g] && cyc < lat + 4) begin
      ab = (cyc >= EXTRA) ? cyc - EXTRA : 0;
      check_value("run_busy", 64'(busy[g]), 64'd1);
      check_value("run_pattern", 64'(pat[g]), 64'(mpat[(cyc < n) ? cyc : n]));
      check_value("run_signature", 64'(sig[g]), 64'(msig[ab]));
      if (cyc == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        check_value("abort_busy", 64'(busy[g]), 64'd0);
        check_value("abort_done", 64'(done[g]), 64'd0);
        check_value("abort_signature", 64'(sig[g]), 64'h0);
        check_value("abort_pattern", 64'(pat[g]), 64'h1);
        rst = 1'b0;
        fault_mask[g] = 7'h00;
        return;
      end
      if (cyc == inject_at) start[g] = 1'b1;
      @(negedge clk);
      start[g] = 1'b0;
      cyc++;
    end
    check_value("done_latency", 64'(cyc), 64'(lat));
    check_value("done_flag", 64'(done[g]), 64'd1);
    check_value("done_busy", 64'(busy[g]), 64'd0);
    check_value("final_signature", 64'(sig[g]), 64'(msig[n]));
    check_value("final_pattern", 64'(pat[g]), 64'(mpat[n]));
    check_value("pass_flag", 64'(pass[g]), fault ? 64'd0 : 64'd1);
    golden[g] = clean ^ 16'(1 << $urandom_range(15, 0));
    #1;
    check_value("pass_bad_golden", 64'(pass[g]), 64'd0);
    golden[g] = clean;
    @(negedge clk);
    check_value("done_hold_signature", 64'(sig[g]), 64'(msig[n]));
    check_value("done_hold_flag", 64'(done[g]), 64'd1);
    fault_mask[g] = 7'h00;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0; golden[i] = 16'h0; mode[i] = 0; key[i] = 36'h0;
      fault_pat[i] = 36'h0; fault_mask[i] = 7'h00;
    end
    mode[1] = 1;
    mode[2] = 2;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check_value("reset_busy", 64'(busy[i]), 64'd0);
      check_value("reset_done", 64'(done[i]), 64'd0);
      check_value("reset_pass", 64'(pass[i]), 64'd0);
      check_value("reset_signature", 64'(sig[i]), 64'h0);
      check_value("reset_pattern", 64'(pat[i]), 64'h1);
    end
    rst = 1'b0;

    run(0, -1, -1, 1'b0);
    check_value("n1_signature", 64'(sig[0]), 64'h0);
    run(1, -1, -1, 1'b0);
    check_value("n2_signature", 64'(sig[1]), 64'h3);
    golden[1] = 16'h0004;
    #1;
    check_value("n2_pass_0004", 64'(pass[1]), 64'd0);
    run(1, -1, -1, 1'b0);

    key[2] = {4'($urandom()), 32'($urandom())};
    run(2, -1, -1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run(2, -1, -1, 1'b0);
    run(2, -1, -1, 1'b1);
    run(2, 5, -1, 1'b0);
    run(2, -1, 3, 1'b0);
    for (int r = 0; r < 6; r++) begin
      key[2] = {4'($urandom()), 32'($urandom())};
      run(2, int'($urandom_range(20, 0)), -1, 1'(r % 2));
    end
    run(0, 0, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
